// File: rtl/pad_cfg_pkg.sv
// Shared types for the configurable pad frame: per-pad config register layout,
// power sequencer states and the registered power-control bundle.
package pad_cfg_pkg;

  typedef struct packed {
    logic       rsvd;
    logic       force_in;
    logic       smt;
    logic       slw;
    logic [1:0] drv;
    logic [1:0] sel;
  } pad_cfg_t;

  // Out of reset every pad is a forced input with function 0 selected.
  localparam pad_cfg_t   PAD_CFG_RST   = pad_cfg_t'(8'h40);
  // The reserved bit is never stored, so it always reads back as 0.
  localparam logic [7:0] PAD_CFG_WMASK = 8'h7F;

  typedef enum logic [2:0] {
    OFF, IO_UP, CORE_UP, BIAS_UP, ACTIVE, RET, RET_EXIT
  } pwr_state_e;

  typedef struct packed {
    logic iopwrok;
    logic pwrok;
    logic bias;
    logic retc;
    logic ready;
    logic freeze;
  } pwr_ctl_t;

  // Power-control levels that belong to each sequencer state.
  function automatic pwr_ctl_t pwr_decode(input pwr_state_e s);
    pwr_ctl_t c;
    c = '0;
    case (s)
      IO_UP:   c.iopwrok = 1'b1;
      CORE_UP: begin c.iopwrok = 1'b1; c.pwrok = 1'b1; end
      BIAS_UP: begin c.iopwrok = 1'b1; c.pwrok = 1'b1; c.bias = 1'b1; end
      ACTIVE:  begin c.iopwrok = 1'b1; c.pwrok = 1'b1; c.bias = 1'b1; c.ready = 1'b1; end
      RET, RET_EXIT: begin
        c.iopwrok = 1'b1; c.pwrok = 1'b1; c.bias = 1'b1;
        c.retc    = 1'b1; c.freeze = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pad_pwr_seq.sv
// Pad-ring power-up / retention sequencer. Steps OFF -> IO_UP -> CORE_UP ->
// BIAS_UP -> ACTIVE, each step PWR_DLY cycles apart, and handles retention
// entry/exit. All outputs come straight from flops.
module pad_pwr_seq
  import pad_cfg_pkg::*;
#(
  parameter int PWR_DLY = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ret_req_i,
  output logic iopwrok_o,
  output logic pwrok_o,
  output logic bias_o,
  output logic retc_o,
  output logic pwr_ready_o,
  output logic freeze_o
);

  localparam int            CW       = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PWR_DLY - 1);

  pwr_state_e    state_q;
  logic [CW-1:0] cnt_q;
  pwr_ctl_t      ctl_q;

  // Next step of the power-up ramp.
  function automatic pwr_state_e up_next(input pwr_state_e s);
    case (s)
      OFF:     return IO_UP;
      IO_UP:   return CORE_UP;
      CORE_UP: return BIAS_UP;
      default: return ACTIVE;
    endcase
  endfunction

  // Sequencer state, step counter and power-control outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      case (state_q)
        OFF, IO_UP, CORE_UP, BIAS_UP: begin
          // Retention requests are ignored until the ring is fully up.
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= up_next(state_q);
            ctl_q   <= pwr_decode(up_next(state_q));
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          cnt_q <= '0;
          if (ret_req_i) begin
            state_q <= RET;
            ctl_q   <= pwr_decode(RET);
          end
        end
        RET: begin
          cnt_q <= '0;
          if (!ret_req_i) begin
            state_q <= RET_EXIT;
            ctl_q   <= pwr_decode(RET_EXIT);
          end
        end
        RET_EXIT: begin
          if (ret_req_i) begin
            cnt_q   <= '0;
            state_q <= RET;
            ctl_q   <= pwr_decode(RET);
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ACTIVE;
            ctl_q   <= pwr_decode(ACTIVE);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= OFF;
          cnt_q   <= '0;
          ctl_q   <= '0;
        end
      endcase
    end
  end

  assign iopwrok_o   = ctl_q.iopwrok;
  assign pwrok_o     = ctl_q.pwrok;
  assign bias_o      = ctl_q.bias;
  assign retc_o      = ctl_q.retc;
  assign pwr_ready_o = ctl_q.ready;
  assign freeze_o    = ctl_q.freeze;

endmodule

// File: rtl/pad_cfg_frame.sv
// Register-programmable pad frame: per-pad config registers, function mux with
// registered pad controls, input synchronisers and the embedded power sequencer.
module pad_cfg_frame
  import pad_cfg_pkg::*;
#(
  parameter  int NUM_PADS    = 16,
  parameter  int NUM_FUNC    = 4,
  parameter  int PWR_DLY     = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [AW-1:0]                cfg_addr_i,
  input  logic [7:0]                   cfg_wdata_i,
  output logic                         cfg_gnt_o,
  output logic                         cfg_rvalid_o,
  output logic [7:0]                   cfg_rdata_o,
  input  logic [NUM_PADS*NUM_FUNC-1:0] func_out_i,
  input  logic [NUM_PADS*NUM_FUNC-1:0] func_oen_i,
  output logic [NUM_PADS-1:0]          func_in_o,
  output logic [NUM_PADS-1:0]          pad_out_o,
  output logic [NUM_PADS-1:0]          pad_oen_o,
  output logic [2*NUM_PADS-1:0]        pad_drv_o,
  output logic [NUM_PADS-1:0]          pad_slw_o,
  output logic [NUM_PADS-1:0]          pad_smt_o,
  input  logic [NUM_PADS-1:0]          pad_in_i,
  output logic                         pwrok_o,
  output logic                         iopwrok_o,
  output logic                         bias_o,
  output logic                         retc_o,
  input  logic                         ret_req_i,
  output logic                         pwr_ready_o
);

  localparam logic [AW:0] NP_LIM = (AW + 1)'(NUM_PADS);
  localparam logic [2:0]  NF_LIM = 3'(NUM_FUNC);

  pad_cfg_t   cfg_q [NUM_PADS];
  pad_cfg_t   wcfg;
  logic       addr_ok;
  logic [7:0] rd_val;
  logic       freeze;

  assign cfg_gnt_o = cfg_req_i;
  assign addr_ok   = ({1'b0, cfg_addr_i} < NP_LIM);
  assign wcfg      = pad_cfg_t'(cfg_wdata_i & PAD_CFG_WMASK);

  // Response data: writes echo the value being stored, unmapped pads read 0.
  always_comb begin
    rd_val = 8'h00;
    if (addr_ok) rd_val = cfg_we_i ? wcfg : cfg_q[cfg_addr_i];
  end

  // Config register file; writes to unmapped pads are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= PAD_CFG_RST;
    end else if (cfg_req_i && cfg_we_i && addr_ok) begin
      cfg_q[cfg_addr_i] <= wcfg;
    end
  end

  // One-cycle access response for every granted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= 8'h00;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      if (cfg_req_i) cfg_rdata_o <= rd_val;
    end
  end

  pad_pwr_seq #(
    .PWR_DLY (PWR_DLY)
  ) u_pwr_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ret_req_i   (ret_req_i),
    .iopwrok_o   (iopwrok_o),
    .pwrok_o     (pwrok_o),
    .bias_o      (bias_o),
    .retc_o      (retc_o),
    .pwr_ready_o (pwr_ready_o),
    .freeze_o    (freeze)
  );

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [3:0]             fo, fe;
    logic                   sel_ok;
    logic                   out_q, oen_q, slw_q, smt_q;
    logic [1:0]             drv_q;
    logic [SYNC_STAGES-1:0] sync_q;

    // Gather this pad's functional sources; unused slots read as disabled.
    always_comb begin
      fo = '0;
      fe = '1;
      for (int f = 0; f < NUM_FUNC; f++) begin
        fo[f] = func_out_i[p*NUM_FUNC + f];
        fe[f] = func_oen_i[p*NUM_FUNC + f];
      end
    end

    assign sel_ok = ({1'b0, cfg_q[p].sel} < NF_LIM);

    // Pad controls: live when ACTIVE, held through retention, safe otherwise.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        out_q <= 1'b0;
        oen_q <= 1'b1;
        drv_q <= 2'b00;
        slw_q <= 1'b0;
        smt_q <= 1'b0;
      end else if (pwr_ready_o) begin
        out_q <= sel_ok & fo[cfg_q[p].sel];
        oen_q <= cfg_q[p].force_in | ~sel_ok | fe[cfg_q[p].sel];
        drv_q <= cfg_q[p].drv;
        slw_q <= cfg_q[p].slw;
        smt_q <= cfg_q[p].smt;
      end else if (!freeze) begin
        out_q <= 1'b0;
        oen_q <= 1'b1;
        drv_q <= 2'b00;
        slw_q <= 1'b0;
        smt_q <= 1'b0;
      end
    end

    // Input synchroniser for the asynchronous pad return path.
    always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in_i[p]};
    end

    assign pad_out_o[p]       = out_q;
    assign pad_oen_o[p]       = oen_q;
    assign pad_drv_o[2*p +: 2] = drv_q;
    assign pad_slw_o[p]       = slw_q;
    assign pad_smt_o[p]       = smt_q;
    assign func_in_o[p]       = sync_q[SYNC_STAGES-1];
  end

endmodule

// File: tb/tb_pad_cfg_frame.sv
// Bench for pad_cfg_frame: directed stimulus, a cycle model of the frame's
// rules compared every cycle, and hand-computed literal expectations.
module tb_pad_cfg_frame;

  // 12 pads so that unmapped indices 12..15 are reachable with a 4-bit address;
  // 3 functions so that sel=3 selects no source.
  localparam int NP = 12;
  localparam int NF = 3;
  localparam int PD = 16;
  localparam int SS = 2;
  localparam int AW = 4;

  logic              clk_i = 1'b0;
  logic              rst_i, cfg_req_i, cfg_we_i, ret_req_i;
  logic [AW-1:0]     cfg_addr_i;
  logic [7:0]        cfg_wdata_i, cfg_rdata_o;
  logic              cfg_gnt_o, cfg_rvalid_o;
  logic [NP*NF-1:0]  func_out_i, func_oen_i;
  logic [NP-1:0]     func_in_o, pad_out_o, pad_oen_o, pad_slw_o, pad_smt_o, pad_in_i;
  logic [2*NP-1:0]   pad_drv_o;
  logic              pwrok_o, iopwrok_o, bias_o, retc_o, pwr_ready_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  pad_cfg_frame #(
    .NUM_PADS(NP), .NUM_FUNC(NF), .PWR_DLY(PD), .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .func_out_i(func_out_i), .func_oen_i(func_oen_i),
    .func_in_o(func_in_o), .pad_out_o(pad_out_o), .pad_oen_o(pad_oen_o),
    .pad_drv_o(pad_drv_o), .pad_slw_o(pad_slw_o), .pad_smt_o(pad_smt_o),
    .pad_in_i(pad_in_i), .pwrok_o(pwrok_o), .iopwrok_o(iopwrok_o), .bias_o(bias_o),
    .retc_o(retc_o), .ret_req_i(ret_req_i), .pwr_ready_o(pwr_ready_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]    m_cfg [NP];
  logic [NP-1:0] m_out, m_oen, m_slw, m_smt;
  logic [2*NP-1:0] m_drv;
  logic [NP-1:0] m_hist [SS];
  int            m_ticks, m_mode, m_exit, m_s;  // m_mode: 0 run, 1 retained, 2 leaving retention
  bit            m_rvalid, m_live = 1'b0, m_up, m_run, m_hold, m_fo, m_fe;
  logic [7:0]    m_rdata;

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NP; p++) m_cfg[p] = 8'h40;
      m_out = '0; m_oen = '1; m_slw = '0; m_smt = '0; m_drv = '0;
      for (int s = 0; s < SS; s++) m_hist[s] = '0;
      m_ticks = 0; m_mode = 0; m_exit = 0;
      m_rvalid = 1'b0; m_rdata = 8'h00; m_live = 1'b1;
    end else begin
      m_up   = (m_ticks >= 4*PD);
      m_run  = m_up && (m_mode == 0);
      m_hold = m_up && (m_mode != 0);
      for (int p = 0; p < NP; p++) begin
        if (m_run) begin
          m_s = int'(m_cfg[p][1:0]);
          if (m_s < NF) begin
            m_fo = func_out_i[p*NF + m_s];
            m_fe = func_oen_i[p*NF + m_s];
          end else begin
            m_fo = 1'b0;
            m_fe = 1'b1;
          end
          m_out[p] = m_fo;
          m_oen[p] = m_cfg[p][6] | m_fe;
          m_drv[2*p +: 2] = m_cfg[p][3:2];
          m_slw[p] = m_cfg[p][4];
          m_smt[p] = m_cfg[p][5];
        end else if (!m_hold) begin
          m_out[p] = 1'b0; m_oen[p] = 1'b1; m_drv[2*p +: 2] = 2'b00;
          m_slw[p] = 1'b0; m_smt[p] = 1'b0;
        end
      end
      m_rvalid = cfg_req_i;
      if (cfg_req_i) begin
        if (int'(cfg_addr_i) < NP) begin
          if (cfg_we_i) m_cfg[cfg_addr_i] = cfg_wdata_i & 8'h7F;
          m_rdata = m_cfg[cfg_addr_i];
        end else begin
          m_rdata = 8'h00;
        end
      end
      for (int s = SS-1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = pad_in_i;
      if (!m_up) begin
        m_ticks++;
      end else begin
        case (m_mode)
          0: if (ret_req_i) m_mode = 1;
          1: if (!ret_req_i) begin m_mode = 2; m_exit = 0; end
          default: begin
            if (ret_req_i) m_mode = 1;
            else begin
              m_exit++;
              if (m_exit == PD) m_mode = 0;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (m_live) begin
      chk("pad_out", pad_out_o, m_out);
      chk("pad_oen", pad_oen_o, m_oen);
      chk("pad_drv", pad_drv_o, m_drv);
      chk("pad_slw", pad_slw_o, m_slw);
      chk("pad_smt", pad_smt_o, m_smt);
      chk("func_in", func_in_o, m_hist[SS-1]);
      chk("pwr_ctl", {iopwrok_o, pwrok_o, bias_o, retc_o, pwr_ready_o},
          {m_ticks >= PD, m_ticks >= 2*PD, m_ticks >= 3*PD,
           (m_ticks >= 4*PD) && (m_mode != 0), (m_ticks >= 4*PD) && (m_mode == 0)});
      chk("rvalid", cfg_rvalid_o, m_rvalid);
      if (m_rvalid) chk("rdata", cfg_rdata_o, m_rdata);
      chk("gnt", cfg_gnt_o, cfg_req_i);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic sig(input int k);
    case (k)
      0:       return iopwrok_o;
      1:       return pwrok_o;
      2:       return bias_o;
      3:       return pwr_ready_o;
      4:       return retc_o;
      default: return func_in_o[0];
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic acc(input bit we, input int addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic v);
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = AW'(addr); cfg_wdata_i = wd;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    rd = cfg_rdata_o; v = cfg_rvalid_o;
  endtask

  task automatic wait_sig(input int k, input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk_i);
      if (sig(k)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int         t [4];
    int         n;
    logic [7:0] rd;
    logic       v;

    rst_i = 1'b1; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0;
    cfg_wdata_i = 8'h00; func_out_i = '0; func_oen_i = '1; pad_in_i = '0;
    ret_req_i = 1'b0;
    cyc(3);
    chk("rst_pwr", {iopwrok_o, pwrok_o, bias_o, retc_o, pwr_ready_o}, 5'b0);
    chk("rst_oen", pad_oen_o, 12'hFFF);
    rst_i = 1'b0;

    // Power-up ramp; a retention request during the ramp must be ignored.
    t = '{-1, -1, -1, -1};
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk_i);
      for (int k = 0; k < 4; k++) if (t[k] < 0 && sig(k)) t[k] = i;
      if (i == 63) chk("oen_before_ready", pad_oen_o, 12'hFFF);
      if (i == 20) ret_req_i = 1'b1;
      if (i == 30) ret_req_i = 1'b0;
    end
    chk("t_iopwrok", t[0], 16);
    chk("t_pwrok",   t[1], 32);
    chk("t_bias",    t[2], 48);
    chk("t_ready",   t[3], 64);

    // Pad 3: sel=1, drv=1, driven from function 1.
    func_out_i[3*NF+1] = 1'b1;
    func_oen_i[3*NF+1] = 1'b0;
    acc(1'b1, 3, 8'h05, rd, v);
    chk("wr3_rvalid", v, 1'b1);
    chk("wr3_rdata", rd, 8'h05);
    cyc(1);
    chk("pad3_out", pad_out_o[3], 1'b1);
    chk("pad3_oen", pad_oen_o[3], 1'b0);
    chk("pad3_drv", pad_drv_o[7:6], 2'b01);

    // Unmapped pads: reads return 0, writes change nothing.
    acc(1'b0, 12, 8'h00, rd, v);
    chk("rd12_rvalid", v, 1'b1);
    chk("rd12_rdata", rd, 8'h00);
    acc(1'b1, 13, 8'hFF, rd, v);
    chk("wr13_rdata", rd, 8'h00);
    acc(1'b0, 3, 8'h00, rd, v);
    chk("rd3_after", rd, 8'h05);
    acc(1'b0, 11, 8'h00, rd, v);
    chk("rd11_after", rd, 8'h40);
    acc(1'b0, 0, 8'h00, rd, v);
    chk("rd0_after", rd, 8'h40);

    // Pad 5: sel=3 selects no source -> output disabled.
    func_out_i[5*NF +: NF] = '1;
    func_oen_i[5*NF +: NF] = '0;
    acc(1'b1, 5, 8'h0B, rd, v);
    cyc(1);
    chk("pad5_oen", pad_oen_o[5], 1'b1);
    chk("pad5_out", pad_out_o[5], 1'b0);
    chk("pad5_drv", pad_drv_o[11:10], 2'b10);

    // Pad 6: sel=2, slew and schmitt on, reserved bit dropped.
    func_out_i[6*NF+2] = 1'b1;
    func_oen_i[6*NF+2] = 1'b0;
    acc(1'b1, 6, 8'hB2, rd, v);
    chk("wr6_rdata", rd, 8'h32);
    cyc(1);
    chk("pad6_out", pad_out_o[6], 1'b1);
    chk("pad6_oen", pad_oen_o[6], 1'b0);
    chk("pad6_slw_smt", {pad_slw_o[6], pad_smt_o[6]}, 2'b11);

    // Back-to-back write then read of pad 1.
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 4'd1; cfg_wdata_i = 8'h0C;
    @(negedge clk_i);
    chk("b2b_wr", {cfg_rvalid_o, cfg_rdata_o}, {1'b1, 8'h0C});
    cfg_we_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_rd", {cfg_rvalid_o, cfg_rdata_o}, {1'b1, 8'h0C});
    cfg_req_i = 1'b0;

    // Input synchroniser.
    pad_in_i = 12'hA5C; cyc(1);
    pad_in_i = 12'h3F0; cyc(1);
    pad_in_i = 12'h000; cyc(3);
    pad_in_i[0] = 1'b1;
    wait_sig(5, 6, n);
    chk("sync_latency", n, SS);

    // Retention: outputs frozen while inputs and config change.
    ret_req_i = 1'b1;
    cyc(1);
    chk("ret_entry", {retc_o, pwr_ready_o}, 2'b10);
    func_out_i = ~func_out_i;
    func_oen_i = ~func_oen_i;
    acc(1'b1, 3, 8'h00, rd, v);
    cyc(2);
    chk("ret_pad3_out", pad_out_o[3], 1'b1);
    chk("ret_pad3_oen", pad_oen_o[3], 1'b0);
    chk("ret_pad3_drv", pad_drv_o[7:6], 2'b01);
    chk("ret_pad6_slw", pad_slw_o[6], 1'b1);
    acc(1'b0, 3, 8'h00, rd, v);
    chk("ret_cfg_written", rd, 8'h00);
    ret_req_i = 1'b0;
    // One edge to leave RET, then PD cycles of exit.
    wait_sig(3, 40, n);
    chk("ret_exit_latency", n, PD + 1);

    // Re-request during exit returns to RET and restarts the exit delay.
    ret_req_i = 1'b1; cyc(2);
    ret_req_i = 1'b0; cyc(5);
    chk("exit_mid", {retc_o, pwr_ready_o}, 2'b10);
    ret_req_i = 1'b1; cyc(1);
    ret_req_i = 1'b0;
    wait_sig(3, 40, n);
    chk("reexit_latency", n, PD + 1);

    // Reset in the middle of the ramp.
    pad_in_i = 12'hFFF;
    rst_i = 1'b1; cyc(1);
    rst_i = 1'b0; cyc(40);
    chk("core_up_state", {iopwrok_o, pwrok_o, bias_o}, 3'b110);
    rst_i = 1'b1; cyc(1);
    chk("midrst_pwr", {iopwrok_o, pwrok_o, bias_o, retc_o, pwr_ready_o}, 5'b0);
    chk("midrst_oen", pad_oen_o, 12'hFFF);
    chk("midrst_drv", pad_drv_o, 24'h0);
    chk("midrst_rsp", {cfg_rvalid_o, cfg_rdata_o}, 9'h0);
    chk("midrst_sync", func_in_o, 12'h000);
    rst_i = 1'b0;
    wait_sig(0, 40, n);
    chk("restart_iopwrok", n, PD);
    acc(1'b0, 3, 8'h00, rd, v);
    chk("rst_cfg3", rd, 8'h40);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
